// File: rtl/pc_trace_monitor.sv
// PC trace monitor: sequences CPU reset, records distinct PCs in a circular trace,
// keeps a rotate-XOR signature and stops on a PC halt or a RUN-cycle timeout.
module pc_trace_monitor #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_CYCLES  = 8,
  parameter int TIMEOUT      = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pc,
  input  logic                     pc_valid,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     cpu_rst,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic [WIDTH-1:0]         signature,
  output logic [31:0]              cycles,
  output logic [1:0]               status,
  output logic                     done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int HCW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t           state_r;
  logic [RCW-1:0]   rst_cnt_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] sig_r;
  logic [31:0]      cycles_r;
  logic [HCW-1:0]   halt_cnt_r;
  logic [WIDTH-1:0] last_pc_r;
  logic             have_last_r;
  logic             cpu_rst_r;
  logic             done_r;

  logic             is_new_s;
  logic             is_rep_s;
  logic [HCW-1:0]   halt_inc_s;
  logic             halt_hit_s;
  logic             timeout_hit_s;
  logic [31:0]      cycles_inc_s;
  logic [AW-1:0]    rd_idx_s;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Classify the current sample and detect halt/timeout for this edge.
  always_comb begin
    is_new_s = 1'b0;
    is_rep_s = 1'b0;
    if (state_r == ST_RUN && pc_valid) begin
      if (!have_last_r || pc != last_pc_r) begin
        is_new_s = 1'b1;
      end else begin
        is_rep_s = 1'b1;
      end
    end else begin
      is_new_s = 1'b0;
      is_rep_s = 1'b0;
    end
    if (cycles_r == 32'hFFFF_FFFF) begin
      cycles_inc_s = cycles_r;
    end else begin
      cycles_inc_s = cycles_r + 32'd1;
    end
    // halt_cnt_r stays below HALT_CYCLES while in RUN, so the increment cannot overflow.
    halt_inc_s    = halt_cnt_r + HCW'(1);
    halt_hit_s    = is_rep_s && (halt_inc_s == HCW'(HALT_CYCLES));
    timeout_hit_s = (state_r == ST_RUN) && (cycles_inc_s == 32'(TIMEOUT));
  end

  // Monitor FSM with trace buffer, signature and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RESET;
      rst_cnt_r   <= {RCW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW + 1){1'b0}};
      sig_r       <= {WIDTH{1'b0}};
      cycles_r    <= 32'd0;
      halt_cnt_r  <= {HCW{1'b0}};
      last_pc_r   <= {WIDTH{1'b0}};
      have_last_r <= 1'b0;
      cpu_rst_r   <= 1'b1;
      done_r      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        ST_RESET: begin
          if (rst_cnt_r + RCW'(1) == RCW'(RESET_CYCLES)) begin
            state_r     <= ST_RUN;
            cpu_rst_r   <= 1'b0;
            rst_cnt_r   <= {RCW{1'b0}};
            have_last_r <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + RCW'(1);
          end
        end
        ST_RUN: begin
          cycles_r <= cycles_inc_s;
          if (is_new_s) begin
            mem_r[wr_ptr_r] <= pc;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
            sig_r           <= rotl1(sig_r) ^ pc;
            halt_cnt_r      <= {HCW{1'b0}};
            last_pc_r       <= pc;
            have_last_r     <= 1'b1;
            if (count_r != (AW + 1)'(DEPTH)) begin
              count_r <= count_r + (AW + 1)'(1);
            end
          end else if (is_rep_s) begin
            halt_cnt_r <= halt_inc_s;
          end
          // Halt takes precedence when both conditions land on the same edge.
          if (halt_hit_s) begin
            state_r <= ST_HALTED;
            done_r  <= 1'b1;
          end else if (timeout_hit_s) begin
            state_r <= ST_TIMEOUT;
            done_r  <= 1'b1;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          state_r <= state_r;
        end
        default: begin
          state_r   <= ST_RESET;
          cpu_rst_r <= 1'b1;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Trace read: index 0 is the newest entry; slots beyond the fill level read as zero.
  always_comb begin
    rd_idx_s = wr_ptr_r - AW'(1) - rd_addr;
    if ({1'b0, rd_addr} < count_r) begin
      rd_data = mem_r[rd_idx_s];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  assign cpu_rst     = cpu_rst_r;
  assign done        = done_r;
  assign status      = state_r;
  assign trace_count = count_r;
  assign signature   = sig_r;
  assign cycles      = cycles_r;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor with DEPTH=4, RESET_CYCLES=2, HALT_CYCLES=3, TIMEOUT=20.
module tb_pc_trace_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic [1:0]  rd_addr;
  logic        cpu_rst;
  logic [31:0] rd_data;
  logic [2:0]  trace_count;
  logic [31:0] signature;
  logic [31:0] cycles;
  logic [1:0]  status;
  logic        done;

  int errors = 0;
  int checks = 0;

  pc_trace_monitor #(
    .WIDTH(32), .DEPTH(4), .RESET_CYCLES(2), .HALT_CYCLES(3), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .rd_addr(rd_addr),
    .cpu_rst(cpu_rst), .rd_data(rd_data), .trace_count(trace_count),
    .signature(signature), .cycles(cycles), .status(status), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [1:0]  ra;
    logic [1:0]  st;
    logic        crst;
    logic        dn;
    logic [2:0]  cnt;
    logic [31:0] sig;
    logic [31:0] rd;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_status"}, 32'(status), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_count"}, 32'(trace_count), 32'd0);
    chk({tag, "_sig"}, signature, 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd"}, rd_data, 32'd0);
  endtask

  // Hold rst for two edges, check reset values, release and walk through the two reset cycles.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    pc_valid = 1'b0;
    rd_addr = 2'd0;
    tick();
    tick();
    check_reset_vals(tag);
    rst = 1'b0;
    chk({tag, "_crst_after_fall"}, 32'(cpu_rst), 32'd1);
    tick();
    chk({tag, "_crst_edge1"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_status_edge1"}, 32'(status), 32'd0);
    tick();
    chk({tag, "_crst_edge2"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_status_edge2"}, 32'(status), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    pc = 32'd0;
    pc_valid = 1'b0;
    rd_addr = 2'd0;

    //         vld   pc      ra    st     crst  dn    cnt   sig     rd      cyc
    tbl[0]  = '{1'b1, 32'd99, 2'd0, 2'b00, 1'b1, 1'b0, 3'd0, 32'd0,  32'd0,  32'd0};
    tbl[1]  = '{1'b1, 32'd99, 2'd0, 2'b01, 1'b0, 1'b0, 3'd0, 32'd0,  32'd0,  32'd0};
    tbl[2]  = '{1'b1, 32'd4,  2'd0, 2'b01, 1'b0, 1'b0, 3'd1, 32'd4,  32'd4,  32'd1};
    tbl[3]  = '{1'b1, 32'd8,  2'd0, 2'b01, 1'b0, 1'b0, 3'd2, 32'd0,  32'd8,  32'd2};
    tbl[4]  = '{1'b1, 32'd12, 2'd2, 2'b01, 1'b0, 1'b0, 3'd3, 32'd12, 32'd4,  32'd3};
    tbl[5]  = '{1'b0, 32'd77, 2'd3, 2'b01, 1'b0, 1'b0, 3'd3, 32'd12, 32'd0,  32'd4};
    tbl[6]  = '{1'b1, 32'd16, 2'd0, 2'b01, 1'b0, 1'b0, 3'd4, 32'd8,  32'd16, 32'd5};
    tbl[7]  = '{1'b1, 32'd20, 2'd3, 2'b01, 1'b0, 1'b0, 3'd4, 32'd4,  32'd8,  32'd6};
    tbl[8]  = '{1'b1, 32'd20, 2'd0, 2'b01, 1'b0, 1'b0, 3'd4, 32'd4,  32'd20, 32'd7};
    tbl[9]  = '{1'b1, 32'd21, 2'd1, 2'b01, 1'b0, 1'b0, 3'd4, 32'd29, 32'd20, 32'd8};
    tbl[10] = '{1'b1, 32'd21, 2'd0, 2'b01, 1'b0, 1'b0, 3'd4, 32'd29, 32'd21, 32'd9};
    tbl[11] = '{1'b1, 32'd21, 2'd0, 2'b01, 1'b0, 1'b0, 3'd4, 32'd29, 32'd21, 32'd10};
    tbl[12] = '{1'b1, 32'd21, 2'd0, 2'b10, 1'b0, 1'b1, 3'd4, 32'd29, 32'd21, 32'd11};
    tbl[13] = '{1'b1, 32'd50, 2'd2, 2'b10, 1'b0, 1'b1, 3'd4, 32'd29, 32'd16, 32'd11};
    tbl[14] = '{1'b1, 32'd51, 2'd3, 2'b10, 1'b0, 1'b1, 3'd4, 32'd29, 32'd12, 32'd11};

    // Table run: starts right as rst falls, so rows 0-1 cover the reset countdown.
    tick();
    tick();
    check_reset_vals("init");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pc_valid = tbl[i].vld;
      pc = tbl[i].pc;
      rd_addr = tbl[i].ra;
      tick();
      chk($sformatf("v%0d_status", i), 32'(status), 32'(tbl[i].st));
      chk($sformatf("v%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].crst));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_count", i), 32'(trace_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_sig", i), signature, tbl[i].sig);
      chk($sformatf("v%0d_rd", i), rd_data, tbl[i].rd);
      chk($sformatf("v%0d_cycles", i), cycles, tbl[i].cyc);
    end

    // Timeout: a fresh PC every RUN cycle; the 20th cycle ends the run.
    do_reset("to");
    for (int i = 0; i < 20; i++) begin
      pc_valid = 1'b1;
      pc = 32'd100 + 32'(i);
      tick();
      chk($sformatf("to_status_c%0d", i + 1), 32'(status), (i < 19) ? 32'd1 : 32'd3);
    end
    chk("to_cycles", cycles, 32'd20);
    chk("to_done", 32'(done), 32'd1);
    chk("to_count", 32'(trace_count), 32'd4);
    rd_addr = 2'd0;
    #1;
    chk("to_rd0_last_sample", rd_data, 32'd119);
    pc = 32'd500;
    tick();
    chk("to_frozen_cycles", cycles, 32'd20);
    chk("to_frozen_status", 32'(status), 32'd3);
    chk("to_frozen_rd0", rd_data, 32'd119);

    // Halt and timeout on the same edge: third repeat falls on RUN cycle 20.
    do_reset("tie");
    for (int i = 0; i < 20; i++) begin
      pc_valid = 1'b1;
      pc = (i < 17) ? 32'd200 + 32'(i) : 32'd216;
      tick();
    end
    chk("tie_status", 32'(status), 32'd2);
    chk("tie_cycles", cycles, 32'd20);
    chk("tie_done", 32'(done), 32'd1);

    // Reset pulsed for one cycle in the middle of a run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    pc_valid = 1'b1;
    pc = 32'd7;
    tick();
    pc = 32'd9;
    tick();
    pc = 32'd11;
    tick();
    chk("mid_count_before", 32'(trace_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_valid = 1'b0;
    check_reset_vals("mid");
    rd_addr = 2'd2;
    #1;
    chk("mid_rd2_cleared", rd_data, 32'd0);
    tick();
    chk("mid_crst_edge1", 32'(cpu_rst), 32'd1);
    chk("mid_status_edge1", 32'(status), 32'd0);
    tick();
    chk("mid_crst_edge2", 32'(cpu_rst), 32'd0);
    chk("mid_status_edge2", 32'(status), 32'd1);
    pc_valid = 1'b1;
    pc = 32'd9;
    rd_addr = 2'd0;
    tick();
    chk("mid_first_sample_rd0", rd_data, 32'd9);
    chk("mid_first_sample_sig", signature, 32'd9);
    chk("mid_first_sample_cycles", cycles, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
